// File: rtl/uart_rx_deframer_if.sv
// Receive-side result bundle: the deframed byte, its strobe, error flags and busy status.
// The deframer drives it through the master modport; the holding logic reads it as slave.
interface uart_rx_deframer_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 parity_error;
  logic                 stop_error;
  logic                 rx_active;

  modport master (
    output data_out,
    output data_valid,
    output parity_error,
    output stop_error,
    output rx_active
  );

  modport slave (
    input data_out,
    input data_valid,
    input parity_error,
    input stop_error,
    input rx_active
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start detection, LSB-first deserialisation,
// optional odd/even parity and stop-bit checks, one-clock delivery strobe.
module uart_rx_deframer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       rx_in,
  input  logic                       sample_tick,
  input  logic [1:0]                 parity_type,
  uart_rx_deframer_if.master         rx_if
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [TickW-1:0]      tick_q, tick_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [1:0]            par_mode_q, par_mode_d;
  logic                  par_bit_q, par_bit_d;
  logic                  wait_high_q, wait_high_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;

  logic                  tick_last;
  logic                  par_enabled;
  logic                  par_mismatch;

  assign tick_last   = (tick_q == TickLast);
  assign par_enabled = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);

  // Odd mode wants an odd count of ones over data plus parity bit, even mode an even count.
  always_comb begin
    par_mismatch = 1'b0;
    unique case (par_mode_q)
      2'b01:   par_mismatch = ~(^shift_q ^ par_bit_q);
      2'b10:   par_mismatch = ^shift_q ^ par_bit_q;
      default: par_mismatch = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_mode_d  = par_mode_q;
    par_bit_d   = par_bit_q;
    wait_high_d = wait_high_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    par_err_d   = par_err_q;
    stop_err_d  = stop_err_q;

    if (sample_tick) begin
      unique case (state_q)
        StIdle: begin
          // After a framing error the line must be seen high before a new start is accepted.
          if (wait_high_q) begin
            if (rx_s_q) wait_high_d = 1'b0;
          end else if (!rx_s_q) begin
            state_d    = StStart;
            tick_d     = '0;
            par_mode_d = parity_type;
          end
        end
        StStart: begin
          if (tick_q == TickHalf) begin
            tick_d = '0;
            if (rx_s_q) begin
              state_d = StIdle;
            end else begin
              state_d = StData;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        StData: begin
          if (tick_last) begin
            tick_d  = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BitW'(1);
            if (bit_q == BitLast) state_d = par_enabled ? StParity : StStop;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        StParity: begin
          if (tick_last) begin
            tick_d    = '0;
            par_bit_d = rx_s_q;
            state_d   = StStop;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        StStop: begin
          if (tick_last) begin
            tick_d      = '0;
            data_d      = shift_q;
            valid_d     = 1'b1;
            stop_err_d  = ~rx_s_q;
            par_err_d   = par_mismatch;
            wait_high_d = ~rx_s_q;
            state_d     = StIdle;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_mode_q  <= 2'b00;
      par_bit_q   <= 1'b0;
      wait_high_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      stop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_in;
      rx_s_q      <= rx_meta_q;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_mode_q  <= par_mode_d;
      par_bit_q   <= par_bit_d;
      wait_high_q <= wait_high_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      par_err_q   <= par_err_d;
      stop_err_q  <= stop_err_d;
    end
  end

  assign rx_if.data_out     = data_q;
  assign rx_if.data_valid   = valid_q;
  assign rx_if.parity_error = par_err_q;
  assign rx_if.stop_error   = stop_err_q;
  assign rx_if.rx_active    = (state_q != StIdle);

endmodule
